// File: rtl/bit_matrix_scan_ctrl.sv
// bit_matrix_scan_ctrl
//   Snapshots a ROWS x COLS constant bit matrix on a start request and streams
//   one cell per valid/ready handshake, highest row/column first, tagging each
//   cell with its absolute row/column index. Counts accepted 1 cells and pulses
//   done for one cycle after the last cell is accepted.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   scan request, sampled only in IDLE
//   mat_in     in   flattened matrix, cell (r,c) at bit r*COLS+(c-COL_BASE)
//   busy       out  high in SCAN and DONE
//   out_valid  out  current cell presented
//   out_ready  in   consumer accepts the cell when out_valid && out_ready
//   out_bit    out  value of the current cell
//   out_row    out  row index of the current cell
//   out_col    out  absolute column index of the current cell
//   ones_cnt   out  accepted 1 cells in the current/last scan
//   done       out  one-cycle pulse after the last accepted cell
module bit_matrix_scan_ctrl #(
    parameter int ROWS     = 2,
    parameter int COLS     = 3,
    parameter int COL_BASE = 1,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW      = ((COL_BASE + COLS) > 1) ? $clog2(COL_BASE + COLS) : 1,
    localparam int NW      = $clog2(ROWS * COLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] mat_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic [RW-1:0]        out_row,
    output logic [CW-1:0]        out_col,
    output logic [NW-1:0]        ones_cnt,
    output logic                 done
);

    localparam int NCELL = ROWS * COLS;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;

    localparam logic [RW-1:0] ROW_TOP = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_TOP = CW'(COL_BASE + COLS - 1);
    localparam logic [CW-1:0] COL_LO  = CW'(COL_BASE);
    localparam logic [IW-1:0] IDX_TOP = IW'(NCELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NCELL-1:0] snap_q,  snap_d;
    logic [RW-1:0]    row_q,   row_d;
    logic [CW-1:0]    col_q,   col_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [NW-1:0]    ones_q,  ones_d;
    logic             cell_bit;

    // The scan order is row-major descending, so the flat snapshot index
    // r*COLS+(c-COL_BASE) simply counts down by one per accepted cell. Keeping
    // it as its own register avoids a multiplier and gives a direct last-cell test.
    assign cell_bit = snap_q[idx_q];

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = mat_in;
                    row_d   = ROW_TOP;
                    col_d   = COL_TOP;
                    idx_d   = IDX_TOP;
                    ones_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    ones_d = ones_q + NW'(cell_bit);
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                        if (col_q == COL_LO) begin
                            col_d = COL_TOP;
                            row_d = row_q - RW'(1);
                        end else begin
                            col_d = col_q - CW'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == SCAN);
    assign done      = (state_q == DONE);
    assign out_bit   = cell_bit;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign ones_cnt  = ones_q;

endmodule
